multiword_add_sequencer: RTL and testbench

- Multi-cycle controller that computes a WORDS*N-bit add or subtract using one shared N-bit ripple-carry slice built from the team's fa full-adder cell.
- Operands are processed one N-bit word per cycle, least-significant word first, with the carry held in a register between words.
- Sits between a requester and a consumer, using a valid/ready handshake on both sides.

---
 rtl/multiword_add_sequencer.sv | 165 ++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer.
// A single N-bit ripple-carry slice, built from fa cells, is reused once per
// word, least-significant word first. The carry between words lives in a
// register. Valid/ready handshakes are used on both the request side and the
// result side.

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiword_add_sequencer #(
    parameter int N     = 5,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    input  logic               cin,
    input  logic               sub,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*WORDS-1:0] res_sum,
    output logic               res_cout,
    output logic               res_ovf,
    output logic               busy
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;

    // Operand A and the pre-conditioned operand B (inverted for subtract).
    logic [W-1:0]    a_r;
    logic [W-1:0]    bx_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            cout_r;
    logic            ovf_r;
    logic [IW-1:0]   idx_r;

    logic            accept_s;
    logic            run_s;
    logic            last_s;
    int              idx_int_s;
    logic [N-1:0]    a_word_s;
    logic [N-1:0]    b_word_s;
    logic [N-1:0]    slice_sum_s;
    logic [N:0]      c_s;

    // The index is held below WORDS, so the part selects stay in range.
    assign last_s    = (idx_r == IW'(WORDS - 1));
    assign idx_int_s = int'(idx_r);
    assign a_word_s  = a_r[idx_int_s*N +: N];
    assign b_word_s  = bx_r[idx_int_s*N +: N];

    // Shared ripple-carry slice. The carry into it comes from the carry register.
    assign c_s[0] = carry_r;
    for (genvar i = 0; i < N; i++) begin : g_slice
        fa u_fa (
            .a  (a_word_s[i]),
            .b  (b_word_s[i]),
            .ci (c_s[i]),
            .s  (slice_sum_s[i]),
            .co (c_s[i+1])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and the per-cycle datapath strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        run_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                // A start request here is ignored; it is taken once the block is back in IDLE.
                if (res_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand capture, word-by-word accumulation and final flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            bx_r    <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= {IW{1'b0}};
        end else if (accept_s) begin
            // Subtract is computed as A + ~B + ~cin. The borrow-in becomes an inverted carry-in.
            a_r     <= op_a;
            bx_r    <= sub ? ~op_b : op_b;
            carry_r <= sub ? ~cin : cin;
            idx_r   <= {IW{1'b0}};
        end else if (run_s) begin
            sum_r[idx_int_s*N +: N] <= slice_sum_s;
            carry_r                 <= c_s[N];
            if (last_s) begin
                cout_r <= c_s[N];
                ovf_r  <= c_s[N-1] ^ c_s[N];
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

    assign start_ready = (state_r == IDLE);
    assign res_valid   = (state_r == DONE);
    assign busy        = (state_r != IDLE);
    assign res_sum     = sum_r;
    assign res_cout    = cout_r;
    assign res_ovf     = ovf_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (N=5, WORDS=4, W=20).
// Expected results were computed by hand.

module tb_multiword_add_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [19:0] op_a;
    logic [19:0] op_b;
    logic        cin;
    logic        sub;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_sum;
    logic        res_cout;
    logic        res_ovf;
    logic        busy;

    int checks_total;
    int checks_passed;

    multiword_add_sequencer #(.N(5), .WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .res_ovf     (res_ovf),
        .busy        (busy)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Called at posedge+1 while the block is in IDLE. The accept happens on the next edge.
    // After the accept, the inputs are scrambled so that any use of them after capture shows up.
    task automatic start_op(input logic [19:0] a, input logic [19:0] b, input logic ci, input logic s);
        op_a        = a;
        op_b        = b;
        cin         = ci;
        sub         = s;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a        = 20'($urandom);
        op_b        = 20'($urandom);
        cin         = ~ci;
        sub         = ~s;
        check_result("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Counts edges after the accept until res_valid rises, up to a fixed bound, then checks the result.
    task automatic wait_result(input string tag, input logic [19:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        check_result({tag, "_latency"}, 32'(lat), 32'd4);
        check_result({tag, "_sum"},  32'(res_sum),  32'(es));
        check_result({tag, "_cout"}, 32'(res_cout), 32'(ec));
        check_result({tag, "_ovf"},  32'(res_ovf),  32'(eo));
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_result({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check_result({tag, "_ready_back"}, 32'(start_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_result({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        check_result({tag, "_busy"},        32'(busy),        32'd0);
        check_result({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check_result({tag, "_res_sum"},     32'(res_sum),     32'd0);
        check_result({tag, "_res_cout"},    32'(res_cout),    32'd0);
        check_result({tag, "_res_ovf"},     32'(res_ovf),     32'd0);
    endtask

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic        ci;
        logic        s;
        logic [19:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    // Main stimulus sequence.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        op_a        = 20'h0;
        op_b        = 20'h0;
        cin         = 1'b0;
        sub         = 1'b0;

        //           a          b          ci    s     sum        cout  ovf
        vecs[0] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[1] = '{20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0};
        vecs[2] = '{20'h00007, 20'h00005, 1'b1, 1'b1, 20'h00001, 1'b1, 1'b0};
        vecs[3] = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1};
        vecs[4] = '{20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1};
        vecs[5] = '{20'h80000, 20'h80000, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b1};
        vecs[6] = '{20'h12345, 20'h54321, 1'b1, 1'b0, 20'h66667, 1'b0, 1'b0};

        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s);
            wait_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure: keep the result held while a new request waits.
        start_op(20'h12345, 20'h54321, 1'b1, 1'b0);
        wait_result("bp_first", 20'h66667, 1'b0, 1'b0);
        op_a        = 20'h00003;
        op_b        = 20'h00004;
        cin         = 1'b0;
        sub         = 1'b0;
        start_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_result("bp_hold_valid", 32'(res_valid), 32'd1);
            check_result("bp_hold_ready", 32'(start_ready), 32'd0);
            check_result("bp_hold_sum", 32'(res_sum), 32'h66667);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_result("bp_idle_ready", 32'(start_ready), 32'd1);
        check_result("bp_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a        = 20'hABCDE;
        check_result("bp_pending_accept", 32'(busy), 32'd1);
        wait_result("bp_pending", 20'h00007, 1'b0, 1'b0);
        release_result("bp_pending");

        // Reset while the operation in flight is on word index 2.
        start_op(20'h00011, 20'h00022, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_run");
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_op(20'h12345, 20'h0000B, 1'b0, 1'b0);
        wait_result("after_rst", 20'h12350, 1'b0, 1'b0);

        // Reset while in DONE drops the pending result.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_done");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_result("post_rst_valid", 32'(res_valid), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
